// File: rtl/pipe_run_controller.sv
// Run controller for the 5-stage pipeline: turns run/step/halt pulses, breakpoint
// and cycle-budget conditions into a shared pipeline enable and a fetch enable.
module pipe_run_controller #(
  parameter int PC_W         = 16,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [CNT_W-1:0] budget,
  output logic             pipe_en,
  output logic             fetch_en,
  output logic             busy,
  output logic             bp_hit,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycles
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_FULL = DRAIN_W'(DRAIN_CYCLES);
  // The breakpoint tick is itself the first bubble of the drain.
  localparam logic [DRAIN_W-1:0] DRAIN_BP   = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               skip_bp_q, skip_bp_d;
  logic               bp_hit_q, bp_hit_d;
  logic               from_halt_q, from_halt_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;

  logic               bp_match;
  logic [CNT_W-1:0]   run_cnt_inc;
  logic               budget_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign bp_match    = bp_en && (pc == bp_addr) && !skip_bp_q;
  assign run_cnt_inc = run_cnt_q + CNT_W'(1);
  assign budget_hit  = (budget != '0) && (run_cnt_inc == budget);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      skip_bp_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
      from_halt_q <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      skip_bp_q   <= skip_bp_d;
      bp_hit_q    <= bp_hit_d;
      from_halt_q <= from_halt_d;
      cycles_q    <= cycles_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    skip_bp_d   = skip_bp_q;
    bp_hit_d    = bp_hit_q;
    from_halt_d = from_halt_q;
    cycles_d    = pipe_en ? sat_inc(cycles_q) : cycles_q;
    unique case (state_q)
      S_IDLE: begin
        if (step_req) begin
          state_d     = S_STEP;
          from_halt_d = 1'b0;
        end else if (run_req) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (fetch_en) begin
          run_cnt_d = run_cnt_inc;
          skip_bp_d = 1'b0;
          if (budget_hit) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_FULL;
          end
        end else if (tick && bp_match) begin
          bp_hit_d    = 1'b1;
          state_d     = (DRAIN_BP == '0) ? S_HALT : S_DRAIN;
          drain_cnt_d = DRAIN_BP;
        end
        // An explicit halt outranks a coincident breakpoint or budget stop.
        if (halt_req) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_FULL;
          bp_hit_d    = bp_hit_q;
        end
      end
      S_STEP: begin
        if (tick || halt_req) state_d = from_halt_q ? S_HALT : S_IDLE;
      end
      S_DRAIN: begin
        if (tick) begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
          if (drain_cnt_q <= DRAIN_W'(1)) state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (step_req) begin
          state_d     = S_STEP;
          from_halt_d = 1'b1;
        end else if (run_req) begin
          state_d   = S_RUN;
          bp_hit_d  = 1'b0;
          run_cnt_d = '0;
          skip_bp_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pipe_en  = 1'b0;
    fetch_en = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        busy     = 1'b1;
        pipe_en  = tick;
        fetch_en = tick && !bp_match;
      end
      S_STEP: begin
        busy     = 1'b1;
        pipe_en  = tick;
        fetch_en = tick;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        pipe_en = tick;
      end
      default: ;
    endcase
  end

  assign state  = state_q;
  assign bp_hit = bp_hit_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_pipe_run_controller.sv
// Scoreboard bench for pipe_run_controller: stimulus queues the expected
// fetch/bubble sequence, a negedge monitor checks each pipeline advance.
module tb_pipe_run_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, tick, run_req, step_req, halt_req, bp_en;
  logic [15:0] bp_addr, pc, budget;
  logic        pipe_en, fetch_en, busy, bp_hit;
  logic [2:0]  state;
  logic [15:0] cycles;

  logic        s_tick, s_run, s_pipe_en, s_fetch_en, s_busy, s_bp_hit;
  logic [2:0]  s_state;
  logic [3:0]  s_cycles;

  logic        pc_clr;
  int          tick_div = 1;
  bit          tick_on  = 1'b0;
  int          ph       = 0;
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    logic        fetch;
    logic [15:0] pc;
  } exp_t;
  exp_t exp_q[$];

  pipe_run_controller #(.PC_W(16), .CNT_W(16), .DRAIN_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .tick(tick), .run_req(run_req),
    .step_req(step_req), .halt_req(halt_req), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .budget(budget), .pipe_en(pipe_en),
    .fetch_en(fetch_en), .busy(busy), .bp_hit(bp_hit), .state(state),
    .cycles(cycles)
  );

  pipe_run_controller #(.PC_W(16), .CNT_W(4), .DRAIN_CYCLES(4)) u_sat (
    .clock(clock), .reset(reset), .tick(s_tick), .run_req(s_run),
    .step_req(1'b0), .halt_req(1'b0), .bp_en(1'b0),
    .bp_addr(16'h0000), .pc(16'h0000), .budget(4'h0), .pipe_en(s_pipe_en),
    .fetch_en(s_fetch_en), .busy(s_busy), .bp_hit(s_bp_hit), .state(s_state),
    .cycles(s_cycles)
  );

  // Program counter model: advances by one 4-byte instruction per fetching tick.
  always @(posedge clock or negedge reset) begin
    if (!reset)                    pc <= 16'h0000;
    else if (pc_clr)               pc <= 16'h0000;
    else if (pipe_en && fetch_en)  pc <= pc + 16'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic f, input logic [15:0] p);
    exp_t e;
    e.fetch = f;
    e.pc    = p;
    exp_q.push_back(e);
  endtask

  task automatic step_clk();
    @(posedge clock);
    #1;
    ph++;
    tick = tick_on && ((ph % tick_div) == 0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, input string name);
    int n = 0;
    while (state !== s && n < maxc) begin
      step_clk();
      n++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset === 1'b1 && pipe_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_advance: pipe_en=1 fetch_en=%b pc=%h, expected no advance",
                 fetch_en, pc);
      end else begin
        e = exp_q.pop_front();
        chk("adv_fetch_en", 32'(fetch_en), 32'(e.fetch));
        chk("adv_pc", 32'(pc), 32'(e.pc));
      end
    end
  end

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; tick = 1'b0; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    bp_en = 1'b0; bp_addr = 16'h0000; budget = 16'h0000; pc_clr = 1'b0;
    s_tick = 1'b0; s_run = 1'b0;
    #2;
    chk("por_state", 32'(state), 32'd0);
    chk("por_pipe_en", 32'(pipe_en), 32'd0);
    chk("por_cycles", 32'(cycles), 32'd0);
    #10 reset = 1'b1;
    step_clk();
    step_clk();

    // Reset in the middle of a free run
    tick_on = 1'b1; tick = 1'b1;
    for (int i = 0; i < 7; i++) push(1'b1, 16'(i * 4));
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    repeat (7) step_clk();
    chk("run_cycles7", 32'(cycles), 32'd7);
    chk("run_state", 32'(state), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pipe_en", 32'(pipe_en), 32'd0);
    chk("rst_fetch_en", 32'(fetch_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    reset = 1'b1;
    repeat (4) step_clk();
    chk("idle_after_rst", 32'(state), 32'd0);
    chk("idle_cycles", 32'(cycles), 32'd0);

    // Single steps from IDLE with tick held high
    for (int k = 0; k < 3; k++) begin
      push(1'b1, 16'(k * 4));
      step_req = 1'b1;
      step_clk();
      step_req = 1'b0;
      chk("step_wait", 32'(state), 32'd2);
      step_clk();
      chk("step_return", 32'(state), 32'd0);
    end
    chk("step_cycles", 32'(cycles), 32'd3);

    // Budget stop with a tick every third clock
    pc_clr = 1'b1;
    step_clk();
    pc_clr = 1'b0;
    budget = 16'd5; tick_div = 3; ph = 0;
    for (int i = 0; i < 5; i++) push(1'b1, 16'(i * 4));
    for (int i = 0; i < 4; i++) push(1'b0, 16'd20);
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    wait_state(3'd4, 60, "budget_halt");
    chk("budget_cycles", 32'(cycles), 32'd12);
    chk("budget_bp_hit", 32'(bp_hit), 32'd0);
    chk("budget_busy", 32'(busy), 32'd0);
    chk("budget_pc", 32'(pc), 32'd20);

    // Breakpoint at 0x000C, then resume from it
    tick_div = 1; budget = 16'd0; bp_en = 1'b1; bp_addr = 16'h000C;
    pc_clr = 1'b1;
    step_clk();
    pc_clr = 1'b0;
    push(1'b1, 16'h0000); push(1'b1, 16'h0004); push(1'b1, 16'h0008);
    for (int i = 0; i < 4; i++) push(1'b0, 16'h000C);
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    wait_state(3'd4, 40, "bp_halt");
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    chk("bp_cycles", 32'(cycles), 32'd19);
    tick_on = 1'b0; tick = 1'b0;
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    chk("bp_hit_clear", 32'(bp_hit), 32'd0);
    chk("resume_state", 32'(state), 32'd1);
    push(1'b1, 16'h000C);
    tick_on = 1'b1; tick = 1'b1;
    step_clk();
    tick_on = 1'b0; tick = 1'b0;
    chk("resume_pc", 32'(pc), 32'h10);
    chk("resume_cycles", 32'(cycles), 32'd20);

    // Coincident halt and step in RUN, requests ignored while draining
    bp_en = 1'b0;
    halt_req = 1'b1; step_req = 1'b1;
    step_clk();
    halt_req = 1'b0; step_req = 1'b0;
    chk("halt_wins", 32'(state), 32'd3);
    for (int i = 0; i < 4; i++) push(1'b0, 16'h0010);
    tick_on = 1'b1; tick = 1'b1;
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    step_req = 1'b1;
    step_clk();
    step_req = 1'b0;
    chk("drain_ignores_req", 32'(state), 32'd3);
    wait_state(3'd4, 20, "drain_halt");
    chk("drain_cycles", 32'(cycles), 32'd24);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_pc", 32'(pc), 32'h10);
    repeat (3) step_clk();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Cycle counter saturation on a 4-bit instance
    s_tick = 1'b1; s_run = 1'b1;
    step_clk();
    s_run = 1'b0;
    repeat (14) step_clk();
    chk("sat_cycles14", 32'(s_cycles), 32'd14);
    repeat (3) step_clk();
    chk("sat_cycles_max", 32'(s_cycles), 32'd15);
    chk("sat_state", 32'(s_state), 32'd1);
    chk("sat_busy", 32'(s_busy), 32'd1);
    chk("sat_pipe_en", 32'(s_pipe_en), 32'd1);
    chk("sat_fetch_en", 32'(s_fetch_en), 32'd1);
    chk("sat_bp_hit", 32'(s_bp_hit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_run_controller.md
Name: pipe_run_controller

Overview:
Sequences the 5-stage pipeline's advance. It produces a single pipeline clock-enable (pipe_en) plus a fetch-enable (fetch_en). When fetch_en is low, IF_ID loads a bubble and the PC holds. The block supports free-run, single-step, PC breakpoint and cycle-budget stops, each with an orderly drain of in-flight instructions. It sits between the debounced UI pulses / rate strobe and the counter, IF_ID and downstream pipeline registers.

Parameters:
PC_W, 16, width of pc and bp_addr
CNT_W, 16, width of cycle counters and budget
DRAIN_CYCLES, 4, enabled ticks with fetch_en=0 needed to retire in-flight instructions

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low; 0 forces all state to reset values
tick  in  1  rate strobe; pipeline may advance only in cycles where tick=1
run_req  in  1  single-cycle pulse: start/resume free run
step_req  in  1  single-cycle pulse: advance one instruction
halt_req  in  1  single-cycle pulse: stop and drain
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
pc  in  PC_W  current fetch PC from counter
budget  in  CNT_W  max fetching ticks per run; 0 = unlimited
pipe_en  out  1  pipeline advance enable (all stage registers)
fetch_en  out  1  1 = fetch rom_out; 0 = insert bubble, hold PC
busy  out  1  1 in RUN, STEP, DRAIN
bp_hit  out  1  sticky: last stop caused by breakpoint
state  out  3  IDLE=0, RUN=1, STEP=2, DRAIN=3, HALT=4
cycles  out  CNT_W  total pipe_en cycles since reset, saturating

Behaviour:
- Reset (reset=0, async): state=IDLE, pipe_en=0, fetch_en=0, busy=0, bp_hit=0, cycles=0. Internal run_cnt=0, drain_cnt=0, skip_bp=0. Reset mid-DRAIN abandons the drain.
- pipe_en and fetch_en are combinational from state, tick and the bp compare. They are 0 whenever tick=0.
- Request priority when pulses coincide: halt_req > step_req > run_req.
- IDLE: run_req -> RUN, clears run_cnt. step_req -> STEP. halt_req ignored.
- RUN: on tick, pipe_en=1, fetch_en=1, run_cnt++.
  - halt_req -> DRAIN, load drain_cnt=DRAIN_CYCLES. The pulse is taken even without tick.
  - Breakpoint: bp_en=1, pc==bp_addr, skip_bp=0 and tick=1 -> that cycle pipe_en=1, fetch_en=0 (instruction at bp_addr not fetched). bp_hit<=1. -> DRAIN with drain_cnt=DRAIN_CYCLES-1.
  - Budget: budget!=0 and run_cnt+1==budget on a fetching tick -> after that tick go to DRAIN with drain_cnt=DRAIN_CYCLES.
  - skip_bp clears on the first fetching tick.
- STEP: waits for tick. On tick, pipe_en=1, fetch_en=1 -> IDLE if entered from IDLE, HALT if entered from HALT. The breakpoint is ignored. halt_req while waiting -> back to origin state with no advance.
- DRAIN: on each tick, pipe_en=1, fetch_en=0, drain_cnt--. When a tick leaves drain_cnt at 0 -> HALT. All requests are ignored.
- HALT: pipe_en=0.
  - run_req -> RUN: bp_hit<=0, run_cnt<=0, skip_bp<=1, so a resume at bp_addr proceeds.
  - step_req -> STEP: bp_hit unchanged.
  - halt_req ignored.
- cycles increments on every clock with pipe_en=1 and saturates at 2^CNT_W-1.
- A fetching tick (fetch_en=1) moves PC by one instruction. A bubble tick holds PC and lets downstream stages advance.

Test Plan:
1. Reset low during RUN with cycles=7 -> immediately state=0, pipe_en=0, cycles=0. After release, no activity until run_req.
2. tick every 3rd clock, run_req, budget=5 -> exactly 5 fetching ticks, then 4 bubble ticks, then state=4. cycles=9, bp_hit=0.
3. bp_en=1, bp_addr=0x000C, pc incrementing by 4 from 0, run -> fetches at pc 0,4,8. At pc=0x000C: pipe_en=1, fetch_en=0, bp_hit=1. Then 3 more bubble ticks, then HALT. run_req -> first tick fetches 0x000C, bp_hit=0.
4. From IDLE, step_req x3 with tick held high -> exactly 3 cycles of pipe_en=fetch_en=1, one per request. Returns to state=0 each time. cycles=3.
5. In RUN, halt_req and step_req in the same cycle -> halt wins: DRAIN, 4 bubble ticks, HALT. run_req/step_req during DRAIN have no effect.
6. Force cycles to 0xFFFE, run 3 ticks -> cycles sticks at 0xFFFF.
